// File: rtl/apb_uart_fifo_ctrl_if.sv
// APB bus bundle for apb_uart_fifo_ctrl.
// PSLVERR is present only when APB_PSLVERR_EN is defined.
interface apb_uart_fifo_ctrl_if;
   // Handshake: the master holds PSEL/PADDR/PWRITE/PWDATA from setup until the
   // access cycle; the transfer completes in the cycle PSEL&PENABLE&PREADY is high,
   // and PRDATA/PSLVERR are valid only in that cycle.
   logic [31:0] PADDR;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
`ifdef APB_PSLVERR_EN
   logic        PSLVERR;
   modport master (output PADDR, PSEL, PENABLE, PWRITE, PWDATA, input PRDATA, PREADY, PSLVERR);
   modport slave  (input PADDR, PSEL, PENABLE, PWRITE, PWDATA, output PRDATA, PREADY, PSLVERR);
`else
   modport master (output PADDR, PSEL, PENABLE, PWRITE, PWDATA, input PRDATA, PREADY);
   modport slave  (input PADDR, PSEL, PENABLE, PWRITE, PWDATA, output PRDATA, PREADY);
`endif
endinterface

// File: rtl/apb_uart_fifo_ctrl.sv
// APB register block with TX/RX FIFOs in front of the UART serializer cores.
// Optional macro APB_PSLVERR_EN adds PSLVERR reporting on the APB interface.
module apb_uart_fifo_ctrl_fifo #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 8,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic              do_push, do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Power-of-2 depth lets the pointers wrap naturally; flush dominates everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end
endmodule

module apb_uart_fifo_ctrl #(
   parameter int                    DEPTH      = 8,
   parameter int                    DATA_W     = 8,
   parameter int                    BAUD_WIDTH = 16,
   parameter logic [BAUD_WIDTH-1:0] BAUD_DIV   = 16'd10417,
   localparam int                   CNT_W      = $clog2(DEPTH) + 1
) (
   input  logic                   PCLK,
   input  logic                   PRESETn,
   apb_uart_fifo_ctrl_if.slave    apb,
   output logic                   irq,
   output logic                   core_tx_start,
   output logic [DATA_W-1:0]      core_tx_data,
   input  logic                   core_tx_done,
   input  logic                   core_tx_busy,
   input  logic [DATA_W-1:0]      core_rx_data,
   input  logic                   core_rx_done,
   input  logic                   core_rx_error,
   input  logic                   core_rx_busy,
   output logic                   core_rx_en,
   output logic                   core_tx_rst,
   output logic                   core_rx_rst,
   output logic [BAUD_WIDTH-1:0]  baud_div,
   output logic [1:0]             tx_state
);
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LAUNCH = 2'd1, ST_WAIT = 2'd2} tx_state_e;
   tx_state_e state, state_nx;

   logic [2:0]        word, irq_en;
   logic              prep, access, wr;
   logic              tx_en, rx_en, rx_overrun, frame_err, tx_overflow;
   logic              tx_push_ok, rx_pop_ok;
   logic              tx_flush, rx_flush, tx_push, tx_drop, tx_pop;
   logic              rx_push, rx_pop, rx_drop;
   logic [DATA_W-1:0] tx_head, rx_head;
   logic [CNT_W-1:0]  tx_count, rx_count;
   logic              tx_full, tx_empty, rx_full, rx_empty;
   logic [8:0]        status;
   logic [31:0]       rdata;
   logic              unused_bits;

   assign word     = apb.PADDR[4:2];
   assign prep     = apb.PSEL && apb.PENABLE && !apb.PREADY;
   assign access   = apb.PSEL && apb.PENABLE && apb.PREADY;
   assign wr       = access && apb.PWRITE;
   assign tx_flush = wr && (word == 3'd0) && apb.PWDATA[2];
   assign rx_flush = wr && (word == 3'd0) && apb.PWDATA[3];
   // Full/empty decisions are frozen in the wait-state cycle so data, error and side effect agree.
   assign tx_push  = wr && (word == 3'd2) && tx_push_ok;
   assign tx_drop  = wr && (word == 3'd2) && !tx_push_ok;
   assign rx_pop   = access && !apb.PWRITE && (word == 3'd3) && rx_pop_ok;
   assign rx_push  = core_rx_done && !core_rx_error;
   assign rx_drop  = rx_push && rx_full && !rx_flush;

   assign core_rx_en  = rx_en;
   assign tx_state    = state;
   assign unused_bits = ^{apb.PADDR[31:5], apb.PADDR[1:0], apb.PWDATA};
   assign status = {tx_overflow, frame_err, rx_overrun, rx_empty, rx_full,
                    tx_empty, tx_full, core_rx_busy, (state != ST_IDLE) || core_tx_busy};

   apb_uart_fifo_ctrl_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_tx_fifo (
      .clk(PCLK), .rst_n(PRESETn), .flush(tx_flush), .push(tx_push), .pop(tx_pop),
      .din(apb.PWDATA[DATA_W-1:0]), .dout(tx_head), .count(tx_count),
      .full(tx_full), .empty(tx_empty));

   apb_uart_fifo_ctrl_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_rx_fifo (
      .clk(PCLK), .rst_n(PRESETn), .flush(rx_flush), .push(rx_push), .pop(rx_pop),
      .din(core_rx_data), .dout(rx_head), .count(rx_count),
      .full(rx_full), .empty(rx_empty));

   always_comb begin
      rdata = '0;
      case (word)
         3'd0: rdata[1:0] = {rx_en, tx_en};
         3'd1: rdata[8:0] = status;
         3'd3: if (!rx_empty) rdata[DATA_W-1:0] = rx_head;
         3'd4: rdata[BAUD_WIDTH-1:0] = baud_div;
         3'd5: begin
            rdata[CNT_W-1:0]   = tx_count;
            rdata[16 +: CNT_W] = rx_count;
         end
         3'd6: rdata[2:0] = irq_en;
         default: ;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         apb.PREADY  <= 1'b0;
         apb.PRDATA  <= '0;
         tx_push_ok  <= 1'b0;
         rx_pop_ok   <= 1'b0;
         tx_en       <= 1'b0;
         rx_en       <= 1'b0;
         irq_en      <= '0;
         baud_div    <= BAUD_DIV;
         rx_overrun  <= 1'b0;
         frame_err   <= 1'b0;
         tx_overflow <= 1'b0;
         irq         <= 1'b0;
         core_tx_rst <= 1'b0;
         core_rx_rst <= 1'b0;
      end else begin
         apb.PREADY  <= apb.PSEL && apb.PENABLE;
         apb.PRDATA  <= (prep && !apb.PWRITE) ? rdata : 32'd0;
         core_tx_rst <= tx_flush;
         core_rx_rst <= rx_flush;
         if (prep) begin
            tx_push_ok <= !tx_full;
            rx_pop_ok  <= !rx_empty;
         end
         if (wr) begin
            case (word)
               3'd0: begin
                  tx_en <= apb.PWDATA[0];
                  rx_en <= apb.PWDATA[1];
               end
               3'd1: begin
                  if (apb.PWDATA[6]) rx_overrun  <= 1'b0;
                  if (apb.PWDATA[7]) frame_err   <= 1'b0;
                  if (apb.PWDATA[8]) tx_overflow <= 1'b0;
               end
               3'd4: baud_div <= apb.PWDATA[BAUD_WIDTH-1:0];
               3'd6: irq_en <= apb.PWDATA[2:0];
               default: ;
            endcase
         end
         // A new error event wins over a simultaneous write-1-to-clear.
         if (rx_drop)                       rx_overrun  <= 1'b1;
         if (core_rx_done && core_rx_error) frame_err   <= 1'b1;
         if (tx_drop)                       tx_overflow <= 1'b1;
         irq <= (irq_en[0] && !rx_empty) || (irq_en[1] && tx_empty) ||
                (irq_en[2] && (rx_overrun || frame_err || tx_overflow));
      end
   end

`ifdef APB_PSLVERR_EN
   logic slverr;
   always_comb begin
      slverr = 1'b0;
      if (word == 3'd7) slverr = 1'b1;
      if (apb.PWRITE && (word == 3'd1) && |(apb.PWDATA & ~32'h0000_01C0)) slverr = 1'b1;
      if (apb.PWRITE && (word == 3'd5)) slverr = 1'b1;
      if (apb.PWRITE && (word == 3'd2) && tx_full) slverr = 1'b1;
      if (!apb.PWRITE && (word == 3'd3) && rx_empty) slverr = 1'b1;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) apb.PSLVERR <= 1'b0;
      else          apb.PSLVERR <= prep && slverr;
   end
`endif

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state        <= ST_IDLE;
         core_tx_data <= '0;
      end else begin
         state <= state_nx;
         if (tx_pop) core_tx_data <= tx_head;
      end
   end

   // Clearing tx_en only gates the IDLE exit, so a character in flight completes.
   always_comb begin
      state_nx      = state;
      tx_pop        = 1'b0;
      core_tx_start = 1'b0;
      case (state)
         ST_IDLE: begin
            if (tx_en && !tx_empty) begin
               tx_pop   = 1'b1;
               state_nx = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            core_tx_start = 1'b1;
            state_nx      = ST_WAIT;
         end
         ST_WAIT: if (core_tx_done) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
      if (tx_flush) begin
         tx_pop   = 1'b0;
         state_nx = ST_IDLE;
      end
   end
endmodule

// File: tb/tb_apb_uart_fifo_ctrl.sv
// Directed, table-driven bench for apb_uart_fifo_ctrl with a simple TX core model.
module tb_apb_uart_fifo_ctrl;
   localparam int DEPTH      = 8;
   localparam int DATA_W     = 8;
   localparam int BAUD_WIDTH = 16;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  irq, core_tx_start, core_rx_en, core_tx_rst, core_rx_rst;
   logic [DATA_W-1:0]     core_tx_data;
   logic                  core_tx_done = 1'b0, core_tx_busy = 1'b0;
   logic [DATA_W-1:0]     core_rx_data = '0;
   logic                  core_rx_done = 1'b0, core_rx_error = 1'b0, core_rx_busy = 1'b0;
   logic [BAUD_WIDTH-1:0] baud_div;
   logic [1:0]            tx_state;

   int n_cmp = 0;
   int n_err = 0;
   int tx_done_cnt = 0, tx_rst_cnt = 0, rx_rst_cnt = 0;
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] rx_exp_q[$];

   typedef struct {
      logic        wr;
      logic [2:0]  word;
      logic [31:0] data;
      logic [31:0] exp;
      string       name;
   } vec_t;
   vec_t vecs[$];

   apb_uart_fifo_ctrl_if bus();

   apb_uart_fifo_ctrl #(
      .DEPTH(DEPTH), .DATA_W(DATA_W), .BAUD_WIDTH(BAUD_WIDTH), .BAUD_DIV(16'd10417)
   ) dut (
      .PCLK(clk), .PRESETn(rst_n), .apb(bus), .irq(irq),
      .core_tx_start(core_tx_start), .core_tx_data(core_tx_data),
      .core_tx_done(core_tx_done), .core_tx_busy(core_tx_busy),
      .core_rx_data(core_rx_data), .core_rx_done(core_rx_done),
      .core_rx_error(core_rx_error), .core_rx_busy(core_rx_busy),
      .core_rx_en(core_rx_en), .core_tx_rst(core_tx_rst), .core_rx_rst(core_rx_rst),
      .baud_div(baud_div), .tx_state(tx_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (core_tx_rst) tx_rst_cnt++;
      if (core_rx_rst) rx_rst_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // TX core model and launch scoreboard: done 20 cycles after each start
   initial begin
      forever begin
         @(posedge clk); #1;
         if (core_tx_start) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL tx_unexpected_start: got launch of 0x%0h, expected none", core_tx_data);
            end else begin
               check("tx_start_data", 32'(core_tx_data), 32'(exp_q.pop_front()));
            end
            repeat (20) @(posedge clk);
            #1 core_tx_done = 1'b1;
            @(posedge clk); #1;
            core_tx_done = 1'b0;
            tx_done_cnt++;
         end
      end
   end

   // driver tasks
   task automatic apb_xfer(input logic wr, input logic [2:0] word, input logic [31:0] wdata,
                           input logic inj, input logic [7:0] inj_byte, output logic [31:0] rdata);
      int waits;
      @(posedge clk); #1;
      bus.PADDR   = {27'd0, word, 2'b00};
      bus.PWRITE  = wr;
      bus.PWDATA  = wdata;
      bus.PSEL    = 1'b1;
      bus.PENABLE = 1'b0;
      @(posedge clk); #1;
      bus.PENABLE = 1'b1;
      waits = 0;
      do begin
         @(posedge clk); #1;
         waits++;
      end while (!bus.PREADY && waits < 8);
      if (!bus.PREADY) begin
         n_cmp++;
         n_err++;
         $display("FAIL apb_timeout: got PREADY=0 after %0d cycles, expected 1", waits);
      end
      rdata = bus.PRDATA;
      if (inj) begin
         core_rx_data = inj_byte;
         core_rx_done = 1'b1;
      end
      @(posedge clk); #1;
      core_rx_done = 1'b0;
      bus.PSEL     = 1'b0;
      bus.PENABLE  = 1'b0;
      bus.PWRITE   = 1'b0;
   endtask

   task automatic apb_write(input logic [2:0] word, input logic [31:0] wdata);
      logic [31:0] dummy;
      apb_xfer(1'b1, word, wdata, 1'b0, 8'd0, dummy);
   endtask

   task automatic read_check(input string name, input logic [2:0] word, input logic [31:0] exp);
      logic [31:0] rd;
      apb_xfer(1'b0, word, 32'd0, 1'b0, 8'd0, rd);
      check(name, rd, exp);
   endtask

   task automatic rx_inject(input logic [7:0] d, input logic err);
      @(posedge clk); #1;
      core_rx_data  = d;
      core_rx_error = err;
      core_rx_done  = 1'b1;
      @(posedge clk); #1;
      core_rx_done  = 1'b0;
      core_rx_error = 1'b0;
   endtask

   // stimulus
   initial begin
      logic [31:0] rd;
      int wait_cyc;
      bus.PADDR = '0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PWDATA = '0;

      vecs.push_back('{1'b0, 3'd0, 32'h0, 32'h0000_0000, "ctrl_rst"});
      vecs.push_back('{1'b0, 3'd1, 32'h0, 32'h0000_0028, "status_rst"});
      vecs.push_back('{1'b0, 3'd2, 32'h0, 32'h0000_0000, "txdata_read"});
      vecs.push_back('{1'b0, 3'd3, 32'h0, 32'h0000_0000, "rxdata_empty"});
      vecs.push_back('{1'b0, 3'd4, 32'h0, 32'h0000_28B1, "bauddiv_rst"});
      vecs.push_back('{1'b0, 3'd5, 32'h0, 32'h0000_0000, "level_rst"});
      vecs.push_back('{1'b0, 3'd6, 32'h0, 32'h0000_0000, "irq_en_rst"});
      vecs.push_back('{1'b0, 3'd7, 32'h0, 32'h0000_0000, "word7_rst"});
      vecs.push_back('{1'b1, 3'd4, 32'h0000_1234, 32'h0, "wr_baud"});
      vecs.push_back('{1'b0, 3'd4, 32'h0, 32'h0000_1234, "bauddiv_rw"});
      vecs.push_back('{1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0, "wr_word7"});
      vecs.push_back('{1'b0, 3'd7, 32'h0, 32'h0000_0000, "word7_ignored"});
      vecs.push_back('{1'b1, 3'd5, 32'h0000_FFFF, 32'h0, "wr_level"});
      vecs.push_back('{1'b0, 3'd5, 32'h0, 32'h0000_0000, "level_readonly"});
      vecs.push_back('{1'b1, 3'd1, 32'h0000_003F, 32'h0, "wr_status_ro"});
      vecs.push_back('{1'b0, 3'd1, 32'h0, 32'h0000_0028, "status_ro_bits"});
      vecs.push_back('{1'b1, 3'd6, 32'h0000_0007, 32'h0, "wr_irq_en"});
      vecs.push_back('{1'b0, 3'd6, 32'h0, 32'h0000_0007, "irq_en_rw"});
      vecs.push_back('{1'b1, 3'd6, 32'h0000_0000, 32'h0, "clr_irq_en"});
      vecs.push_back('{1'b1, 3'd0, 32'h0000_000F, 32'h0, "wr_ctrl_flush"});
      vecs.push_back('{1'b0, 3'd0, 32'h0, 32'h0000_0003, "ctrl_flush_selfclr"});
      vecs.push_back('{1'b1, 3'd0, 32'h0000_0000, 32'h0, "clr_ctrl"});
      vecs.push_back('{1'b1, 3'd4, 32'h0000_0100, 32'h0, "wr_baud2"});

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_core_tx_start", 32'(core_tx_start), 32'd0);
      check("rst_core_tx_data", 32'(core_tx_data), 32'd0);
      check("rst_core_rsts", 32'({core_tx_rst, core_rx_rst, core_rx_en}), 32'd0);
      check("rst_pready_prdata", 32'(bus.PREADY) | bus.PRDATA, 32'd0);
      check("rst_baud_port", 32'(baud_div), 32'h28B1);
      check("rst_tx_state", 32'(tx_state), 32'd0);

      foreach (vecs[i]) begin
         if (vecs[i].wr) apb_write(vecs[i].word, vecs[i].data);
         else            read_check(vecs[i].name, vecs[i].word, vecs[i].exp);
      end
      check("baud_port_written", 32'(baud_div), 32'h0100);

      // TX: three characters launched in order
      exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
      apb_write(3'd2, 32'h41); apb_write(3'd2, 32'h42); apb_write(3'd2, 32'h43);
      read_check("tx_level_3", 3'd5, 32'd3);
      read_check("tx_status_loaded", 3'd1, 32'h20);
      apb_write(3'd0, 32'h1);
      wait_cyc = 0;
      while (tx_done_cnt < 3 && wait_cyc < 400) begin
         @(posedge clk); #1;
         wait_cyc++;
      end
      check("tx_three_done", 32'(tx_done_cnt), 32'd3);
      check("tx_launch_count", 32'(exp_q.size()), 32'd0);
      read_check("tx_level_0", 3'd5, 32'd0);
      read_check("tx_status_drained", 3'd1, 32'h28);

      // TX overflow, flush keeps sticky flag, then W1C
      apb_write(3'd0, 32'h0);
      for (int i = 0; i < DEPTH + 1; i++) apb_write(3'd2, 32'h10 + i);
      read_check("tx_level_full", 3'd5, DEPTH);
      read_check("tx_status_full_ovf", 3'd1, 32'h124);
      tx_rst_cnt = 0;
      apb_write(3'd0, 32'h4);
      read_check("tx_level_flushed", 3'd5, 32'd0);
      read_check("tx_flush_keeps_sticky", 3'd1, 32'h128);
      check("tx_rst_pulse_flush", 32'(tx_rst_cnt), 32'd1);
      apb_write(3'd1, 32'h100);
      read_check("tx_ovf_w1c", 3'd1, 32'h28);

      // RX overrun and drain order
      for (int i = 0; i < DEPTH + 1; i++) begin
         rx_inject(8'(i), 1'b0);
         if (rx_exp_q.size() < DEPTH) rx_exp_q.push_back(8'(i));
      end
      read_check("rx_status_full_ovr", 3'd1, 32'h58);
      read_check("rx_level_full", 3'd5, DEPTH << 16);
      for (int i = 0; i < DEPTH; i++) read_check("rx_pop_data", 3'd3, 32'(rx_exp_q.pop_front()));
      read_check("rx_status_drained", 3'd1, 32'h68);
      read_check("rx_read_empty", 3'd3, 32'd0);
      apb_write(3'd1, 32'h40);
      rx_inject(8'h99, 1'b1);
      read_check("rx_frame_err", 3'd1, 32'hA8);
      read_check("rx_frame_no_push", 3'd5, 32'd0);
      apb_write(3'd1, 32'h80);

      // interrupt timing on rx_not_empty
      apb_write(3'd6, 32'h1);
      @(posedge clk); #1;
      check("irq_idle", 32'(irq), 32'd0);
      rx_inject(8'h5A, 1'b0);
      check("irq_not_early", 32'(irq), 32'd0);
      @(posedge clk); #1;
      check("irq_after_push", 32'(irq), 32'd1);
      read_check("irq_rx_data", 3'd3, 32'h5A);
      @(posedge clk); #1;
      check("irq_cleared", 32'(irq), 32'd0);
      apb_write(3'd6, 32'h0);

      // same-cycle push and pop at level 2
      rx_inject(8'h11, 1'b0);
      rx_inject(8'h22, 1'b0);
      apb_xfer(1'b0, 3'd3, 32'd0, 1'b1, 8'h33, rd);
      check("pushpop_data", rd, 32'h11);
      read_check("pushpop_level", 3'd5, 32'h0002_0000);
      read_check("pushpop_next1", 3'd3, 32'h22);
      read_check("pushpop_next2", 3'd3, 32'h33);

      // flush mid-character: 0x77 launches, 0x88 never does
      apb_write(3'd0, 32'h1);
      exp_q.push_back(8'h77);
      apb_write(3'd2, 32'h77);
      apb_write(3'd2, 32'h88);
      tx_rst_cnt = 0;
      apb_write(3'd0, 32'h5);
      check("flush_fsm_idle", 32'(tx_state), 32'd0);
      read_check("flush_tx_level", 3'd5, 32'd0);
      check("flush_tx_rst_pulse", 32'(tx_rst_cnt), 32'd1);
      repeat (60) @(posedge clk);
      #1;
      check("flush_launches", 32'(exp_q.size()), 32'd0);
      read_check("flush_status", 3'd1, 32'h28);
      apb_write(3'd0, 32'h0);

      // rx flush
      rx_inject(8'h01, 1'b0);
      rx_inject(8'h02, 1'b0);
      rx_rst_cnt = 0;
      apb_write(3'd0, 32'h8);
      read_check("rx_flush_level", 3'd5, 32'd0);
      check("rx_rst_pulse", 32'(rx_rst_cnt), 32'd1);

      // reset mid-operation
      apb_write(3'd2, 32'h55);
      rx_inject(8'h66, 1'b0);
      apb_write(3'd6, 32'h1);
      @(posedge clk); #1;
      check("irq_before_reset", 32'(irq), 32'd1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("midrst_irq", 32'(irq), 32'd0);
      check("midrst_baud", 32'(baud_div), 32'h28B1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      read_check("midrst_status", 3'd1, 32'h28);
      read_check("midrst_level", 3'd5, 32'd0);
      read_check("midrst_irq_en", 3'd6, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      n_cmp++;
      n_err++;
      $display("FAIL watchdog: got no completion by 200000 ns, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
